ysyx_23060061_lsu: RTL

Parametrised multi-cycle load/store unit between the ysyx_23060061 core's execute stage and data memory. It replaces the single-cycle, word-only direct memory port with a valid/ready request channel, a handshaked memory bus, sub-word access sizes with byte-lane steering, and load sign/zero extension. It generates the byte write mask that was previously fixed at 4'b1111.

---
 rtl/ysyx_23060061_lsu.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060061_lsu.sv
// Multi-cycle load/store unit: valid/ready core request, handshaked memory bus, byte-lane steering.
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned accesses instead of force-aligning them).
//
// state  | meaning
// IDLE   | ready for a core request
// REQ    | memory request presented, waiting for mem_ready
// WAIT_R | load issued, waiting for mem_rvalid
// RESP   | one-cycle response pulse
module ysyx_23060061_lsu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

  state_t           state;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [OFF_W-1:0] off_q;

  logic [OFF_W-1:0]  in_off;
  logic [OFF_W-1:0]  lsb_mask;
  logic [OFF_W-1:0]  in_off_eff;
  logic [NB-1:0]     size_bytes;
  logic              misaligned;
  logic              illegal;
  logic              in_err;
  logic [NB-1:0]     in_wmask;
  logic [DATA_W-1:0] in_wdata;
  logic [ADDR_W-1:0] in_addr;

  always_comb begin
    in_off = req_addr[OFF_W-1:0];
    case (req_size)
      2'b00:   begin lsb_mask = OFF_W'(3'd0); size_bytes = NB'(8'h01); end
      2'b01:   begin lsb_mask = OFF_W'(3'd1); size_bytes = NB'(8'h03); end
      2'b10:   begin lsb_mask = OFF_W'(3'd3); size_bytes = NB'(8'h0F); end
      default: begin lsb_mask = OFF_W'(3'd7); size_bytes = NB'(8'hFF); end
    endcase
    misaligned = |(in_off & lsb_mask);
    illegal    = (DATA_W == 32) && (req_size == 2'b11);
`ifdef MISALIGN_TRAP_EN
    in_err     = illegal | misaligned;
    in_off_eff = in_off;
`else
    in_err     = illegal;
    in_off_eff = in_off & ~lsb_mask;
`endif
    in_wmask = size_bytes << in_off_eff;
    in_wdata = req_wdata << {in_off_eff, 3'b000};
    in_addr  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  end

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] load_ext;
  logic [3:0]        nbytes_q;
  logic              top_bit;
  logic              fill;

  // Bytes beyond the access size are filled with the sign (or zero) of the top loaded byte.
  always_comb begin
    shifted  = mem_rdata >> {off_q, 3'b000};
    nbytes_q = 4'd1 << size_q;
    case (size_q)
      2'b00:   top_bit = shifted[7];
      2'b01:   top_bit = shifted[15];
      2'b10:   top_bit = shifted[31];
      default: top_bit = shifted[DATA_W-1];
    endcase
    fill     = top_bit & ~uns_q;
    load_ext = '0;
    for (int b = 0; b < NB; b++) begin
      load_ext[8*b +: 8] = (b < int'(nbytes_q)) ? shifted[8*b +: 8] : {8{fill}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      size_q    <= '0;
      uns_q     <= 1'b0;
      off_q     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            off_q     <= in_off_eff;
            mem_we    <= req_we;
            mem_addr  <= in_addr;
            mem_wdata <= in_wdata;
            mem_wmask <= in_wmask;
            req_ready <= 1'b0;
            if (in_err) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state     <= REQ;
              mem_valid <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            if (mem_we) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= '0;
            end else begin
              state <= WAIT_R;
            end
          end
        end
        WAIT_R: begin
          if (mem_rvalid) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= load_ext;
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
